// File: rtl/skid_buff.sv
// skid_buff: two-entry registered valid/ready pipeline buffer (main + skid register)
// with synchronous flush; IN_READY and Y_VALID decode from registered state only.
module skid_buff #(
   parameter int N      = 32,
   parameter int DPFLAG = 1,
   parameter     GROUP  = "dpath1",
   parameter int d_Y    = 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         FLUSH,
   input  logic [N-1:0] IN0,
   input  logic         IN_VALID,
   output logic         IN_READY,
   output logic [N-1:0] Y,
   output logic         Y_VALID,
   input  logic         Y_READY,
   output logic [1:0]   OCC
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   state_t       r_state, w_next;
   logic [N-1:0] r_y, r_skid;
   logic         w_accept, w_deliver, w_load_y, w_y_from_skid, w_load_skid, w_unused;
   // Layout-only parameters are folded here so they are referenced but carry no logic.
   assign w_unused  = (DPFLAG != 0) ^ (|GROUP) ^ (d_Y != 0);
   assign IN_READY  = r_state != TWO;
   assign Y_VALID   = r_state != EMPTY;
   assign OCC       = r_state;
   assign Y         = r_y;
   assign w_accept  = IN_VALID && IN_READY;
   assign w_deliver = Y_VALID && Y_READY;
   always_comb begin
      w_next        = r_state;
      w_load_y      = 1'b0;
      w_y_from_skid = 1'b0;
      w_load_skid   = 1'b0;
      case (r_state)
         EMPTY: begin
            w_next   = w_accept ? ONE : EMPTY;
            w_load_y = w_accept;
         end
         ONE: begin
            w_next      = (w_accept && !w_deliver) ? TWO : (!w_accept && w_deliver) ? EMPTY : ONE;
            w_load_y    = w_accept && w_deliver;
            w_load_skid = w_accept && !w_deliver;
         end
         TWO: begin
            w_next        = w_deliver ? ONE : TWO;
            w_load_y      = w_deliver;
            w_y_from_skid = 1'b1;
         end
         default: w_next = EMPTY;
      endcase
   end
   // Flush empties the buffer but leaves the data registers untouched.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= EMPTY;
         r_y     <= '0;
         r_skid  <= '0;
      end else if (FLUSH) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_next;
         if (w_load_y) r_y <= w_y_from_skid ? r_skid : IN0;
         if (w_load_skid) r_skid <= IN0;
      end
   end
endmodule

// File: tb/tb_skid_buff.sv
// tb_skid_buff: directed scenarios plus randomized traffic checked against a
// queue-based model of a two-word FIFO buffer.
module tb_skid_buff;
   logic        CLK = 1'b0, RST, FLUSH, IN_VALID, Y_READY;
   logic [31:0] IN0;
   logic        IN_READY, Y_VALID;
   logic [31:0] Y;
   logic [1:0]  OCC;
   int          checks = 0, failures = 0;
   logic [31:0] m_q[$];
   logic [31:0] m_y;

   skid_buff #(.N(32)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN0(IN0), .IN_VALID(IN_VALID),
      .IN_READY(IN_READY), .Y(Y), .Y_VALID(Y_VALID), .Y_READY(Y_READY), .OCC(OCC)
   );

   always #5 CLK = ~CLK;

   task automatic step(input logic rst, input logic fl, input logic iv, input logic [31:0] d, input logic yr);
      bit acc, del;
      RST = rst; FLUSH = fl; IN_VALID = iv; IN0 = d; Y_READY = yr;
      @(posedge CLK);
      if (rst) begin
         m_q.delete();
         m_y = '0;
      end else if (fl) begin
         m_q.delete();
      end else begin
         acc = iv && m_q.size() < 2;
         del = m_q.size() > 0 && yr;
         if (del) void'(m_q.pop_front());
         if (acc) m_q.push_back(d);
      end
      if (m_q.size() > 0) m_y = m_q[0];
      #1;
   endtask

   task automatic test_reset();
      step(1, 0, 1, 32'hDEADBEEF, 1);
      step(1, 0, 1, 32'hDEADBEEF, 1);
      checks++;
      if ({Y_VALID, IN_READY, OCC, Y} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
         failures++;
         $display("FAIL reset: got v=%b r=%b occ=%0d y=%h, want v=0 r=1 occ=0 y=0", Y_VALID, IN_READY, OCC, Y);
      end
      step(0, 0, 0, 32'h0, 1);
      checks++;
      if ({Y_VALID, OCC, Y} !== {1'b0, 2'd0, 32'h0}) begin
         failures++;
         $display("FAIL reset_idle: got v=%b occ=%0d y=%h, want v=0 occ=0 y=0", Y_VALID, OCC, Y);
      end
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 3; i++) begin
         step(0, 0, 1, 32'(i), 1);
         checks++;
         if ({Y_VALID, IN_READY, OCC, Y} !== {1'b1, 1'b1, 2'd1, 32'(i)}) begin
            failures++;
            $display("FAIL stream[%0d]: got v=%b r=%b occ=%0d y=%h, want v=1 r=1 occ=1 y=%h", i, Y_VALID, IN_READY, OCC, Y, 32'(i));
         end
      end
      step(0, 0, 0, 32'h0, 1);
   endtask

   task automatic test_backpressure();
      step(0, 0, 1, 32'hA, 0);
      checks++;
      if ({IN_READY, OCC, Y} !== {1'b1, 2'd1, 32'hA}) begin
         failures++;
         $display("FAIL bp_one: got r=%b occ=%0d y=%h, want r=1 occ=1 y=a", IN_READY, OCC, Y);
      end
      step(0, 0, 1, 32'hB, 0);
      checks++;
      if ({Y_VALID, IN_READY, OCC, Y} !== {1'b1, 1'b0, 2'd2, 32'hA}) begin
         failures++;
         $display("FAIL bp_two: got v=%b r=%b occ=%0d y=%h, want v=1 r=0 occ=2 y=a", Y_VALID, IN_READY, OCC, Y);
      end
      step(0, 0, 1, 32'hC, 0);
      checks++;
      if ({IN_READY, OCC, Y} !== {1'b0, 2'd2, 32'hA}) begin
         failures++;
         $display("FAIL bp_ignore_c: got r=%b occ=%0d y=%h, want r=0 occ=2 y=a", IN_READY, OCC, Y);
      end
      step(0, 0, 1, 32'hC, 1);
      checks++;
      if ({Y_VALID, OCC, Y} !== {1'b1, 2'd1, 32'hB}) begin
         failures++;
         $display("FAIL bp_b: got v=%b occ=%0d y=%h, want v=1 occ=1 y=b", Y_VALID, OCC, Y);
      end
      step(0, 0, 1, 32'hC, 1);
      checks++;
      if ({Y_VALID, OCC, Y} !== {1'b1, 2'd1, 32'hC}) begin
         failures++;
         $display("FAIL bp_c: got v=%b occ=%0d y=%h, want v=1 occ=1 y=c", Y_VALID, OCC, Y);
      end
      step(0, 0, 0, 32'h0, 1);
      checks++;
      if ({Y_VALID, OCC} !== {1'b0, 2'd0}) begin
         failures++;
         $display("FAIL bp_empty: got v=%b occ=%0d, want v=0 occ=0", Y_VALID, OCC);
      end
   endtask

   task automatic test_drain();
      logic [34:0] want[3];
      want[0] = {1'b1, 2'd1, 32'hB};
      want[1] = {1'b0, 2'd0, 32'hB};
      want[2] = {1'b0, 2'd0, 32'hB};
      step(0, 0, 1, 32'hA, 0);
      step(0, 0, 1, 32'hB, 0);
      checks++;
      if ({Y_VALID, OCC, Y} !== {1'b1, 2'd2, 32'hA}) begin
         failures++;
         $display("FAIL drain_start: got v=%b occ=%0d y=%h, want v=1 occ=2 y=a", Y_VALID, OCC, Y);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 32'h0, 1);
         checks++;
         if ({Y_VALID, OCC, Y} !== want[i]) begin
            failures++;
            $display("FAIL drain[%0d]: got %h, want %h", i, {Y_VALID, OCC, Y}, want[i]);
         end
      end
   endtask

   task automatic test_flush();
      step(0, 0, 1, 32'h11, 0);
      step(0, 0, 1, 32'h22, 0);
      step(0, 1, 1, 32'h33, 1);
      checks++;
      if ({Y_VALID, IN_READY, OCC, Y} !== {1'b0, 1'b1, 2'd0, 32'h11}) begin
         failures++;
         $display("FAIL flush: got v=%b r=%b occ=%0d y=%h, want v=0 r=1 occ=0 y=11", Y_VALID, IN_READY, OCC, Y);
      end
      step(0, 0, 1, 32'h55, 0);
      checks++;
      if ({Y_VALID, OCC, Y} !== {1'b1, 2'd1, 32'h55}) begin
         failures++;
         $display("FAIL flush_next: got v=%b occ=%0d y=%h, want v=1 occ=1 y=55", Y_VALID, OCC, Y);
      end
      step(0, 0, 0, 32'h0, 1);
      checks++;
      if ({Y_VALID, OCC} !== {1'b0, 2'd0}) begin
         failures++;
         $display("FAIL flush_alone: got v=%b occ=%0d, want v=0 occ=0", Y_VALID, OCC);
      end
   endtask

   task automatic test_rst_over_flush();
      step(0, 0, 1, 32'h77, 0);
      step(1, 1, 1, 32'h99, 1);
      checks++;
      if ({Y_VALID, IN_READY, OCC, Y} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
         failures++;
         $display("FAIL rst_over_flush: got v=%b r=%b occ=%0d y=%h, want v=0 r=1 occ=0 y=0", Y_VALID, IN_READY, OCC, Y);
      end
   endtask

   task automatic test_random();
      logic [35:0] exp_v;
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(63) == 0, $urandom_range(15) == 0, 1'($urandom), $urandom, 1'($urandom));
         exp_v = {m_q.size() != 0, m_q.size() < 2, 2'(m_q.size()), m_y};
         checks++;
         if ({Y_VALID, IN_READY, OCC, Y} !== exp_v) begin
            failures++;
            $display("FAIL random[%0d]: got v=%b r=%b occ=%0d y=%h, want %h", i, Y_VALID, IN_READY, OCC, Y, exp_v);
         end
      end
   endtask

   initial begin
      RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; IN0 = '0; Y_READY = 1'b0;
      m_y = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_drain();
      test_flush();
      test_rst_over_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
